hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller feeding the execute stage. It tracks in-flight destination registers, LR writes and FL writes in a shadow pipeline (Ex, Me slots). It produces the forwarding selects consumed by execute, registered so they are aligned with the instruction in Ex, plus the load-use stall, the branch/jump flush and the global memory freeze controls for fetch/decode.

## Interface
- REG_ADDR_W, 5, register index width
- CNT_W, 32, performance counter width (only with HAZARD_PERF_CNT_EN)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  decode holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  decode source indices
- id_rs1_en, id_rs2_en  in  1  source actually read
- id_rd  in  REG_ADDR_W  decode destination
- id_reg_wrt_en  in  1  decode writes id_rd
- id_mem_rd  in  1  decode is a load (data ready in Wb)
- id_lr_rd, id_lr_wrt  in  1  decode reads LR as operand 1 / writes LR
- id_fl_rd, id_fl_wrt  in  1  decode consumes FL / writes FL
- ex_redirect  in  1  taken branch or jump resolved in Ex
- mem_busy  in  1  memory stage not done; freeze
- stall_if_id  out  1  hold PC and IF/ID register
- bubble_id_ex  out  1  load NOP into DeEx instead of decode
- flush_if_id  out  1  replace IF/ID with NOP
- freeze_all  out  1  hold every pipeline register
- forward1_sel  out  2  0 reg, 1 ExMe ALU, 2 WB data, 3 forwarded LR
- forward2_sel  out  2  0 reg, 1 ExMe ALU, 2 WB data (3 never driven)
- forward_LR_sel  out  1  0 ExMe LR, 1 MeWb LR
- forward_FL_sel  out  2  0 DeEx FL, 1 ExMe FL, 2 MeWb FL

## Operation
- Slot record: valid, rd, reg_wrt, mem_rd, lr_wrt, fl_wrt. Slots: EX (instr now in Ex), ME (instr now in Me).
- Each advancing cycle: ME<=EX; EX<=decode record, or invalid if bubble_id_ex. On freeze_all: slots and selects hold.
- Src match: X matches slot S if S.valid & S.reg_wrt & S.rd==X & src_en.
- Forward select for decode (registered into Ex): EX-slot match ->1; else ME-slot match ->2; else 0. Youngest wins.
- Operand 1 with id_lr_rd: EX.lr_wrt -> sel1=3, LR_sel=0; else ME.lr_wrt -> sel1=3, LR_sel=1; else sel1=0 (decode supplies LR in reg_1).
- FL with id_fl_rd: EX.fl_wrt ->1, else ME.fl_wrt ->2, else 0.
- Load-use: id_valid & EX.mem_rd & EX-slot match on either source -> stall_if_id=1, bubble_id_ex=1. The next cycle, the load is in ME and select 2 is used.
- WB-stage writes are not tracked; the register file bypasses same-cycle writes.
- Priority: mem_busy > ex_redirect > load-use. freeze_all=mem_busy; all other controls 0 while frozen.
- ex_redirect: flush_if_id=1, bubble_id_ex=1, stall_if_id=0. The flushed decode instruction never enters EX.
- A bubble writes selects 0.

## Timing
- stall_if_id, bubble_id_ex, flush_if_id, freeze_all: combinational, same cycle.
- Forward selects: registered, 1-cycle latency, valid during Ex of the instruction decoded the previous cycle.
- Reset (rst_n low at posedge): slots invalid, all selects 0. Combinational outputs are 0 except freeze_all, which follows mem_busy.
- Load-use penalty 1 cycle; redirect penalty 2 cycles.
- Back-to-back loads to the same rd: each load-use stall is evaluated independently.
- mem_busy during a pending load-use holds the stall condition. The stall resolves after the unfreeze.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs stall_cnt, flush_cnt (CNT_W).
  - stall_cnt increments each load-use stall cycle; flush_cnt increments each redirect cycle.
  - Counters saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- hazard_pkg: fwd1_e, fwd2_e, fl_fwd_e enums matching the encodings above, slot_t struct, REG_ADDR_W default.
- One sub-module: hazard_slot_match (combinational slot-vs-source compare, instantiated per slot/source).

## Test plan
- Reset, then ADD r3 followed by ADD r4,r3,r1 -> next cycle forward1_sel=1; one cycle later in Ex forward1_sel=2 if one instruction sits between them.
- LOAD r5 then ADD r6,r5,r5 -> stall_if_id=1, bubble_id_ex=1 for 1 cycle; then forward1_sel=2, forward2_sel=2.
- JAL (lr_wrt) then instr with id_lr_rd -> forward1_sel=3, forward_LR_sel=0; with one NOP between -> LR_sel=1.
- CMP (fl_wrt) then branch (fl_rd) -> forward_FL_sel=1; both EX and ME write FL -> 1 (youngest).
- ex_redirect coinciding with a load-use condition -> flush_if_id=1, bubble_id_ex=1, stall_if_id=0.
- mem_busy high 3 cycles mid-sequence -> freeze_all=1, selects and slots unchanged, no stall/flush counted.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
//   - REG_ADDR_W / CNT_W : register index width and default perf-counter width
//   - fwd1_e / fwd2_e    : operand forwarding selects consumed by execute
//   - fl_fwd_e           : flag forwarding select
//   - lr_fwd_e           : link-register forwarding select
//   - slot_t             : shadow-pipeline record of an in-flight instruction
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [1:0] {
    Fwd1Reg  = 2'd0,
    Fwd1ExMe = 2'd1,
    Fwd1Wb   = 2'd2,
    Fwd1Lr   = 2'd3
  } fwd1_e;

  typedef enum logic [1:0] {
    Fwd2Reg  = 2'd0,
    Fwd2ExMe = 2'd1,
    Fwd2Wb   = 2'd2
  } fwd2_e;

  typedef enum logic [1:0] {
    FlDeEx = 2'd0,
    FlExMe = 2'd1,
    FlMeWb = 2'd2
  } fl_fwd_e;

  typedef enum logic {
    LrExMe = 1'b0,
    LrMeWb = 1'b1
  } lr_fwd_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_wrt;
    logic                  mem_rd;
    logic                  lr_wrt;
    logic                  fl_wrt;
  } slot_t;

  // Youngest producer wins: a hit in the EX slot shadows one in the ME slot.
  function automatic fwd2_e pick_src(input logic hit_ex, input logic hit_me);
    if (hit_ex) begin
      return Fwd2ExMe;
    end else if (hit_me) begin
      return Fwd2Wb;
    end
    return Fwd2Reg;
  endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// hazard_slot_match: combinational compare of one shadow slot against one
// decode source register.
//   valid_i   : slot holds a real instruction
//   wrt_i     : slot instruction writes its destination register
//   rd_i      : slot destination index
//   src_i     : decode source index
//   src_en_i  : decode actually reads src_i
//   match_o   : source depends on the slot's result
module hazard_slot_match
  import hazard_pkg::*;
(
  input  logic                  valid_i,
  input  logic                  wrt_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  src_en_i,
  output logic                  match_o
);

  assign match_o = valid_i & wrt_i & src_en_i & (rd_i == src_i);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller feeding the execute stage.
// Tracks in-flight destinations, LR and FL writers in two shadow slots (EX, ME)
// and produces registered forwarding selects aligned with the instruction in
// Ex, plus combinational stall / bubble / flush / freeze controls.
//
// Ports:
//   clk_i, rst_ni               clock, synchronous active-low reset
//   id_*_i                      decode-stage instruction description
//   ex_redirect_i               taken branch / jump resolved in Ex
//   mem_busy_i                  memory stage not done (freezes everything)
//   stall_if_id_o               hold PC and IF/ID
//   bubble_id_ex_o              load NOP into DeEx
//   flush_if_id_o               replace IF/ID with NOP
//   freeze_all_o                hold every pipeline register
//   forward1_sel_o/2_sel_o      operand forwarding selects (registered)
//   forward_lr_sel_o            LR source when forward1_sel_o == 3 (registered)
//   forward_fl_sel_o            flag forwarding select (registered)
//   stall_cnt_o, flush_cnt_o    saturating perf counters, only when the
//                               HAZARD_PERF_CNT_EN macro is defined
module hazard_unit
  import hazard_pkg::*;
`ifdef HAZARD_PERF_CNT_EN
#(
  parameter int unsigned CntW = CNT_W
)
`endif
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_en_i,
  input  logic                  id_rs2_en_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_wrt_en_i,
  input  logic                  id_mem_rd_i,
  input  logic                  id_lr_rd_i,
  input  logic                  id_lr_wrt_i,
  input  logic                  id_fl_rd_i,
  input  logic                  id_fl_wrt_i,
  input  logic                  ex_redirect_i,
  input  logic                  mem_busy_i,
  output logic                  stall_if_id_o,
  output logic                  bubble_id_ex_o,
  output logic                  flush_if_id_o,
  output logic                  freeze_all_o,
  output logic [1:0]            forward1_sel_o,
  output logic [1:0]            forward2_sel_o,
  output logic                  forward_lr_sel_o,
  output logic [1:0]            forward_fl_sel_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CntW-1:0]       stall_cnt_o,
  output logic [CntW-1:0]       flush_cnt_o
`endif
);

  slot_t   ex_q, ex_d, me_q, me_d;
  slot_t   id_rec;
  fwd1_e   sel1_q, sel1_d;
  fwd2_e   sel2_q, sel2_d;
  lr_fwd_e lr_sel_q, lr_sel_d;
  fl_fwd_e fl_sel_q, fl_sel_d;

  logic rs1_ex_hit, rs1_me_hit, rs2_ex_hit, rs2_me_hit;
  logic load_use;
  logic freeze;

  // Fields are qualified by id_valid_i so an invalid decode leaves a clean slot.
  always_comb begin
    id_rec         = '0;
    id_rec.valid   = id_valid_i;
    id_rec.rd      = id_rd_i;
    id_rec.reg_wrt = id_valid_i & id_reg_wrt_en_i;
    id_rec.mem_rd  = id_valid_i & id_mem_rd_i;
    id_rec.lr_wrt  = id_valid_i & id_lr_wrt_i;
    id_rec.fl_wrt  = id_valid_i & id_fl_wrt_i;
  end

  hazard_slot_match u_match_rs1_ex (
    .valid_i  (ex_q.valid),
    .wrt_i    (ex_q.reg_wrt),
    .rd_i     (ex_q.rd),
    .src_i    (id_rs1_i),
    .src_en_i (id_rs1_en_i),
    .match_o  (rs1_ex_hit)
  );

  hazard_slot_match u_match_rs1_me (
    .valid_i  (me_q.valid),
    .wrt_i    (me_q.reg_wrt),
    .rd_i     (me_q.rd),
    .src_i    (id_rs1_i),
    .src_en_i (id_rs1_en_i),
    .match_o  (rs1_me_hit)
  );

  hazard_slot_match u_match_rs2_ex (
    .valid_i  (ex_q.valid),
    .wrt_i    (ex_q.reg_wrt),
    .rd_i     (ex_q.rd),
    .src_i    (id_rs2_i),
    .src_en_i (id_rs2_en_i),
    .match_o  (rs2_ex_hit)
  );

  hazard_slot_match u_match_rs2_me (
    .valid_i  (me_q.valid),
    .wrt_i    (me_q.reg_wrt),
    .rd_i     (me_q.rd),
    .src_i    (id_rs2_i),
    .src_en_i (id_rs2_en_i),
    .match_o  (rs2_me_hit)
  );

  // A load's data only appears in Wb, so a consumer directly behind it waits one cycle.
  assign load_use = id_valid_i & ex_q.mem_rd & (rs1_ex_hit | rs2_ex_hit);
  assign freeze   = mem_busy_i;

  assign freeze_all_o = freeze;

  // Priority: freeze > redirect > load-use. Everything but freeze is quiet in reset.
  always_comb begin
    stall_if_id_o  = 1'b0;
    bubble_id_ex_o = 1'b0;
    flush_if_id_o  = 1'b0;
    if (rst_ni && !freeze) begin
      if (ex_redirect_i) begin
        flush_if_id_o  = 1'b1;
        bubble_id_ex_o = 1'b1;
      end else if (load_use) begin
        stall_if_id_o  = 1'b1;
        bubble_id_ex_o = 1'b1;
      end
    end
  end

  always_comb begin
    me_d     = ex_q;
    ex_d     = bubble_id_ex_o ? slot_t'('0) : id_rec;
    sel1_d   = Fwd1Reg;
    sel2_d   = Fwd2Reg;
    lr_sel_d = LrExMe;
    fl_sel_d = FlDeEx;
    if (!bubble_id_ex_o) begin
      sel2_d = pick_src(rs2_ex_hit, rs2_me_hit);
      // LR operand takes over operand 1; with no LR writer in flight decode
      // already placed LR on reg_1, so the register path is correct.
      if (id_lr_rd_i) begin
        if (ex_q.lr_wrt) begin
          sel1_d = Fwd1Lr;
        end else if (me_q.lr_wrt) begin
          sel1_d   = Fwd1Lr;
          lr_sel_d = LrMeWb;
        end
      end else begin
        sel1_d = fwd1_e'(pick_src(rs1_ex_hit, rs1_me_hit));
      end
      if (id_fl_rd_i) begin
        if (ex_q.fl_wrt) begin
          fl_sel_d = FlExMe;
        end else if (me_q.fl_wrt) begin
          fl_sel_d = FlMeWb;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_q     <= '0;
      me_q     <= '0;
      sel1_q   <= Fwd1Reg;
      sel2_q   <= Fwd2Reg;
      lr_sel_q <= LrExMe;
      fl_sel_q <= FlDeEx;
    end else if (!freeze) begin
      ex_q     <= ex_d;
      me_q     <= me_d;
      sel1_q   <= sel1_d;
      sel2_q   <= sel2_d;
      lr_sel_q <= lr_sel_d;
      fl_sel_q <= fl_sel_d;
    end
  end

  assign forward1_sel_o   = sel1_q;
  assign forward2_sel_o   = sel2_q;
  assign forward_lr_sel_o = lr_sel_q;
  assign forward_fl_sel_o = fl_sel_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CntW-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_if_id_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CntW'(1);
      end
      if (flush_if_id_o && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CntW'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with hand-computed expectations.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_en, id_rs2_en, id_reg_wrt_en, id_mem_rd;
  logic       id_lr_rd, id_lr_wrt, id_fl_rd, id_fl_wrt;
  logic       ex_redirect, mem_busy;
  logic       stall_if_id, bubble_id_ex, flush_if_id, freeze_all;
  logic [1:0] forward1_sel, forward2_sel, forward_fl_sel;
  logic       forward_lr_sel;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .id_valid_i       (id_valid),
    .id_rs1_i         (id_rs1),
    .id_rs2_i         (id_rs2),
    .id_rs1_en_i      (id_rs1_en),
    .id_rs2_en_i      (id_rs2_en),
    .id_rd_i          (id_rd),
    .id_reg_wrt_en_i  (id_reg_wrt_en),
    .id_mem_rd_i      (id_mem_rd),
    .id_lr_rd_i       (id_lr_rd),
    .id_lr_wrt_i      (id_lr_wrt),
    .id_fl_rd_i       (id_fl_rd),
    .id_fl_wrt_i      (id_fl_wrt),
    .ex_redirect_i    (ex_redirect),
    .mem_busy_i       (mem_busy),
    .stall_if_id_o    (stall_if_id),
    .bubble_id_ex_o   (bubble_id_ex),
    .flush_if_id_o    (flush_if_id),
    .freeze_all_o     (freeze_all),
    .forward1_sel_o   (forward1_sel),
    .forward2_sel_o   (forward2_sel),
    .forward_lr_sel_o (forward_lr_sel),
    .forward_fl_sel_o (forward_fl_sel)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o      (stall_cnt),
    .flush_cnt_o      (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid      = 1'b0;
    id_rs1        = '0;
    id_rs2        = '0;
    id_rd         = '0;
    id_rs1_en     = 1'b0;
    id_rs2_en     = 1'b0;
    id_reg_wrt_en = 1'b0;
    id_mem_rd     = 1'b0;
    id_lr_rd      = 1'b0;
    id_lr_wrt     = 1'b0;
    id_fl_rd      = 1'b0;
    id_fl_wrt     = 1'b0;
  endtask

  // Valid decode: destination, sources, load flag. LR/FL flags cleared.
  task automatic dec(input logic [4:0] rd, input logic wrt, input logic [4:0] rs1,
                     input logic e1, input logic [4:0] rs2, input logic e2, input logic ld);
    idle();
    id_valid      = 1'b1;
    id_rd         = rd;
    id_reg_wrt_en = wrt;
    id_rs1        = rs1;
    id_rs1_en     = e1;
    id_rs2        = rs2;
    id_rs2_en     = e2;
    id_mem_rd     = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n       = 1'b0;
    mem_busy    = 1'b1;
    ex_redirect = 1'b1;
    tick();
    tick();
    check("rst_freeze", 32'(freeze_all), 32'd1);
    check("rst_flush", 32'(flush_if_id), 32'd0);
    check("rst_bubble", 32'(bubble_id_ex), 32'd0);
    check("rst_stall", 32'(stall_if_id), 32'd0);
    check("rst_sel1", 32'(forward1_sel), 32'd0);
    check("rst_sel2", 32'(forward2_sel), 32'd0);
    check("rst_lr", 32'(forward_lr_sel), 32'd0);
    check("rst_fl", 32'(forward_fl_sel), 32'd0);
    mem_busy    = 1'b0;
    ex_redirect = 1'b0;
    #1;
    check("rst_freeze_lo", 32'(freeze_all), 32'd0);
    rst_n = 1'b1;

    // ALU forwarding: ADD r3; ADD r4,r3,r1; use r4 (EX) and r3 (ME)
    dec(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    dec(5'd4, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
    #1;
    check("alu_nostall", 32'(stall_if_id), 32'd0);
    tick();
    check("alu_sel1_ex", 32'(forward1_sel), 32'd1);
    check("alu_sel2_none", 32'(forward2_sel), 32'd0);
    dec(5'd0, 1'b0, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    check("alu2_sel1_ex", 32'(forward1_sel), 32'd1);
    check("alu2_sel2_me", 32'(forward2_sel), 32'd2);

    // Load-use: LOAD r5; ADD r6,r5,r5
    dec(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    dec(5'd6, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    check("lu_stall", 32'(stall_if_id), 32'd1);
    check("lu_bubble", 32'(bubble_id_ex), 32'd1);
    check("lu_flush", 32'(flush_if_id), 32'd0);
    tick();
    check("lu_bub_sel1", 32'(forward1_sel), 32'd0);
    check("lu_bub_sel2", 32'(forward2_sel), 32'd0);
    check("lu_stall_gone", 32'(stall_if_id), 32'd0);
    tick();
    check("lu_sel1_wb", 32'(forward1_sel), 32'd2);
    check("lu_sel2_wb", 32'(forward2_sel), 32'd2);

    // LR forwarding
    idle(); id_valid = 1'b1; id_lr_wrt = 1'b1;
    tick();
    idle(); id_valid = 1'b1; id_lr_rd = 1'b1;
    tick();
    check("lr_ex_sel1", 32'(forward1_sel), 32'd3);
    check("lr_ex_lrsel", 32'(forward_lr_sel), 32'd0);
    idle(); id_valid = 1'b1; id_lr_wrt = 1'b1;
    tick();
    idle(); id_valid = 1'b1;
    tick();
    idle(); id_valid = 1'b1; id_lr_rd = 1'b1;
    tick();
    check("lr_me_sel1", 32'(forward1_sel), 32'd3);
    check("lr_me_lrsel", 32'(forward_lr_sel), 32'd1);
    // No LR writer in flight: operand 1 comes from the register path even if rs1 matches
    dec(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    dec(5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
    id_lr_rd = 1'b1;
    tick();
    check("lr_none_sel1", 32'(forward1_sel), 32'd0);
    check("lr_none_lrsel", 32'(forward_lr_sel), 32'd0);

    // FL forwarding
    idle(); id_valid = 1'b1; id_fl_wrt = 1'b1;
    tick();
    idle(); id_valid = 1'b1; id_fl_rd = 1'b1;
    tick();
    check("fl_ex", 32'(forward_fl_sel), 32'd1);
    idle(); id_valid = 1'b1; id_fl_wrt = 1'b1;
    tick();
    tick();
    idle(); id_valid = 1'b1; id_fl_rd = 1'b1;
    tick();
    check("fl_youngest", 32'(forward_fl_sel), 32'd1);
    idle(); id_valid = 1'b1; id_fl_wrt = 1'b1;
    tick();
    idle(); id_valid = 1'b1;
    tick();
    idle(); id_valid = 1'b1; id_fl_rd = 1'b1;
    tick();
    check("fl_me", 32'(forward_fl_sel), 32'd2);

    // Both slots write r8: youngest (EX) wins
    dec(5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    dec(5'd0, 1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    check("yng_sel1", 32'(forward1_sel), 32'd1);
    check("yng_sel2", 32'(forward2_sel), 32'd1);

    // Redirect coinciding with load-use
    dec(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    dec(5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    ex_redirect = 1'b1;
    #1;
    check("rd_flush", 32'(flush_if_id), 32'd1);
    check("rd_bubble", 32'(bubble_id_ex), 32'd1);
    check("rd_stall", 32'(stall_if_id), 32'd0);
    tick();
    ex_redirect = 1'b0;
    idle();
    check("rd_sel1", 32'(forward1_sel), 32'd0);
    tick();

    // Freeze during a pending load-use
    dec(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    dec(5'd10, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1);
    tick();
    check("fz_pre_sel1", 32'(forward1_sel), 32'd1);
    dec(5'd11, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    check("fz_pre_stall", 32'(stall_if_id), 32'd1);
    mem_busy = 1'b1;
    #1;
    check("fz_freeze", 32'(freeze_all), 32'd1);
    check("fz_stall", 32'(stall_if_id), 32'd0);
    check("fz_bubble", 32'(bubble_id_ex), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fz_hold_sel1", 32'(forward1_sel), 32'd1);
      check("fz_hold_freeze", 32'(freeze_all), 32'd1);
      check("fz_hold_stall", 32'(stall_if_id), 32'd0);
    end
    mem_busy = 1'b0;
    #1;
    check("fz_rel_freeze", 32'(freeze_all), 32'd0);
    check("fz_rel_stall", 32'(stall_if_id), 32'd1);
    check("fz_rel_bubble", 32'(bubble_id_ex), 32'd1);
    tick();
    check("fz_bub_sel1", 32'(forward1_sel), 32'd0);
    check("fz_bub_stall", 32'(stall_if_id), 32'd0);
    tick();
    check("fz_sel1_wb", 32'(forward1_sel), 32'd2);

`ifdef HAZARD_PERF_CNT_EN
    check("cnt_stall", stall_cnt, 32'd2);
    check("cnt_flush", flush_cnt, 32'd1);
`endif

    // Reset mid-run clears registered selects
    idle();
    rst_n = 1'b0;
    tick();
    check("rst2_sel1", 32'(forward1_sel), 32'd0);
    check("rst2_sel2", 32'(forward2_sel), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst2_cnt", stall_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
